// File: rtl/enc2_input_debounce_if.sv
// rtl/enc2_input_debounce_if.sv - raw request lines in, debounced levels and edge pulses out
//
// Signals:
//   D_raw          [3:0] raw asynchronous request lines, bit i maps to Di
//   D0..D3               debounced levels, wired straight to the Enc_2 D inputs
//   press          [3:0] one-cycle pulse when debounced bit i goes 0->1
//   release_pulse  [3:0] one-cycle pulse when debounced bit i goes 1->0
//   changed              OR of press and release_pulse, same cycle
//
// master: the side that owns the raw lines and consumes the debounced view.
// slave:  the debounce block itself.
interface enc2_input_debounce_if;
  logic [3:0] D_raw;
  logic       D0;
  logic       D1;
  logic       D2;
  logic       D3;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic       changed;

  modport master (
    output D_raw,
    input  D0, D1, D2, D3,
    input  press, release_pulse, changed
  );

  modport slave (
    input  D_raw,
    output D0, D1, D2, D3,
    output press, release_pulse, changed
  );
endinterface

// File: rtl/enc2_input_debounce.sv
// rtl/enc2_input_debounce.sv - four-channel synchronise-and-debounce front end for Enc_2
//
// Ports:
//   clk  system clock, all state moves on the rising edge
//   rst  synchronous active-high reset, clears every flop
//   bus  enc2_input_debounce_if.slave
//          D_raw in, D0..D3 / press / release_pulse / changed out (all registered)
//
// Each channel runs a two-flop synchroniser followed by a counter that must
// see STABLE_CYCLES consecutive disagreeing samples before the debounced
// level follows. Any agreeing sample in between restarts the count, so
// shorter glitches never reach the outputs.
module enc2_input_debounce #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  enc2_input_debounce_if.slave   bus
);

  // Per-channel view: STABLE while the synchronised sample matches the
  // debounced level, COUNTING while it disagrees.
  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       level;
  logic [CNT_W-1:0] cnt [4];
  logic [0:0]       state [4];
  logic [3:0]       flip;
  logic [3:0]       press_q;
  logic [3:0]       release_q;
  logic             changed_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state[i] = (sync2[i] != level[i]) ? ST_COUNTING : ST_STABLE;
      // The final disagreeing sample flips the level at this edge.
      flip[i]  = (state[i] == ST_COUNTING) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      press_q   <= '0;
      release_q <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= bus.D_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (state[i] == ST_STABLE) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      // Pulses land in the same cycle the new level becomes visible.
      press_q   <= flip & sync2;
      release_q <= flip & ~sync2;
      changed_q <= |flip;
    end
  end

  assign bus.D0            = level[0];
  assign bus.D1            = level[1];
  assign bus.D2            = level[2];
  assign bus.D3            = level[3];
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.changed       = changed_q;

endmodule
